// File: rtl/magia_tb_pkg.sv
// Shared types and width helpers for the MAGIA testbench end-of-computation collector.
package magia_tb_pkg;

    localparam int N_TILES = 4;

    typedef enum logic [1:0] {
        EOC_IDLE,
        EOC_RUN,
        EOC_DONE,
        EOC_TIMEOUT
    } eoc_state_e;

    localparam int unsigned EOC_PASS_STATUS = '0;

    function automatic int cnt_w(int n);
        return $clog2(n + 1);
    endfunction

    function automatic int id_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_DONE_W = cnt_w(N_TILES);
    localparam int ID_W     = id_w(N_TILES);

endpackage

// File: rtl/magia_tb_eoc_collector_if.sv
// Per-tile exit-status report channel between the tile array and the EoC collector.
interface magia_tb_eoc_collector_if #(
    parameter int N_TILES  = magia_tb_pkg::N_TILES,
    parameter int STATUS_W = 32
);
    // Handshake: a report transfers on a cycle where eoc_valid[i] and eoc_ready[i]
    // are both high. Valid may drop without a transfer; ready never depends on status.
    logic [N_TILES-1:0]          eoc_valid;
    logic [N_TILES*STATUS_W-1:0] eoc_status;
    logic [N_TILES-1:0]          eoc_ready;

    modport master (output eoc_valid, output eoc_status, input eoc_ready);
    modport slave  (input eoc_valid, input eoc_status, output eoc_ready);

endinterface

// File: rtl/magia_tb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, which
// moves past the grant whenever advance_i is high.
module magia_tb_rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = magia_tb_pkg::id_w(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] gnt_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (gnt_id_o == ID_W'(N - 1)) ? '0 : gnt_id_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/magia_tb_eoc_collector.sv
// Collects one exit status per tile, tracks pass/fail and runs an optional watchdog
// (present only when MAGIA_TB_WATCHDOG_EN is defined).
module magia_tb_eoc_collector
    import magia_tb_pkg::*;
#(
    parameter int N_TILES        = magia_tb_pkg::N_TILES,
    parameter int STATUS_W       = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 32,
    localparam int N_DONE_W      = magia_tb_pkg::cnt_w(N_TILES),
    localparam int ID_W          = magia_tb_pkg::id_w(N_TILES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    magia_tb_eoc_collector_if.slave eoc,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic                  dup_o,
    output logic [N_DONE_W-1:0]   n_done_o,
    output logic [N_DONE_W-1:0]   fail_cnt_o,
    output logic [ID_W-1:0]       first_fail_id_o,
    output logic [STATUS_W-1:0]   first_fail_status_o,
    output logic [CNT_W-1:0]      cycles_o,
    output eoc_state_e            state_o
);

    eoc_state_e          state_q, state_d;
    logic [N_TILES-1:0]  done_vec_q, done_vec_d;
    logic [N_DONE_W-1:0] n_done_q, n_done_d, fail_cnt_q, fail_cnt_d;
    logic [ID_W-1:0]     ff_id_q, ff_id_d;
    logic [STATUS_W-1:0] ff_status_q, ff_status_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                dup_q, dup_d;
    logic                run, accept, wd_expire;
    logic [N_TILES-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [STATUS_W-1:0] gnt_status;

    assign run        = (state_q == EOC_RUN);
    assign accept     = run && (|(eoc.eoc_valid & gnt));
    assign eoc.eoc_ready = run ? gnt : '0;
    assign gnt_status = eoc.eoc_status[int'(gnt_id)*STATUS_W +: STATUS_W];

    magia_tb_rr_arbiter #(.N(N_TILES)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (eoc.eoc_valid),
        .advance_i (accept),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

`ifdef MAGIA_TB_WATCHDOG_EN
    assign wd_expire = (cycles_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = (state_q == EOC_TIMEOUT);
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        done_vec_d  = done_vec_q;
        n_done_d    = n_done_q;
        fail_cnt_d  = fail_cnt_q;
        ff_id_d     = ff_id_q;
        ff_status_d = ff_status_q;
        cycles_d    = cycles_q;
        dup_d       = dup_q;
        case (state_q)
            EOC_IDLE: if (start_i) state_d = EOC_RUN;
            EOC_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
                if (accept) begin
                    if (done_vec_q[gnt_id]) begin
                        dup_d = 1'b1;
                    end else begin
                        done_vec_d[gnt_id] = 1'b1;
                        n_done_d = n_done_q + N_DONE_W'(1);
                        if (gnt_status != STATUS_W'(EOC_PASS_STATUS)) begin
                            fail_cnt_d = fail_cnt_q + N_DONE_W'(1);
                            if (fail_cnt_q == '0) begin
                                ff_id_d     = gnt_id;
                                ff_status_d = gnt_status;
                            end
                        end
                    end
                end
                // A last accept in the expiry cycle still counts as completion.
                if (n_done_d == N_DONE_W'(N_TILES)) state_d = EOC_DONE;
                else if (wd_expire)                 state_d = EOC_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= EOC_IDLE;
            done_vec_q  <= '0;
            n_done_q    <= '0;
            fail_cnt_q  <= '0;
            ff_id_q     <= '0;
            ff_status_q <= '0;
            cycles_q    <= '0;
            dup_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_vec_q  <= done_vec_d;
            n_done_q    <= n_done_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_id_q     <= ff_id_d;
            ff_status_q <= ff_status_d;
            cycles_q    <= cycles_d;
            dup_q       <= dup_d;
        end
    end

    assign done_o              = (state_q == EOC_DONE);
    assign pass_o              = done_o && (fail_cnt_q == '0);
    assign dup_o               = dup_q;
    assign n_done_o            = n_done_q;
    assign fail_cnt_o          = fail_cnt_q;
    assign first_fail_id_o     = ff_id_q;
    assign first_fail_status_o = ff_status_q;
    assign cycles_o            = cycles_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_magia_tb_eoc_collector.sv
// Bench for magia_tb_eoc_collector: directed scenarios plus randomized runs against a
// behavioural model; follows MAGIA_TB_WATCHDOG_EN the same way the design does.
module tb_magia_tb_eoc_collector;
    import magia_tb_pkg::*;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int TO = 100;
    localparam int CW = 32;
    localparam int DW = $clog2(N + 1);
    localparam int IW = 2;
`ifdef MAGIA_TB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          done, pass, timeout, dup;
    logic [DW-1:0] n_done, fail_cnt;
    logic [IW-1:0] ff_id;
    logic [SW-1:0] ff_st;
    logic [CW-1:0] cycles;
    eoc_state_e    state;

    magia_tb_eoc_collector_if #(.N_TILES(N), .STATUS_W(SW)) eoc_if ();

    magia_tb_eoc_collector #(
        .N_TILES(N), .STATUS_W(SW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .eoc(eoc_if),
        .done_o(done), .pass_o(pass), .timeout_o(timeout), .dup_o(dup),
        .n_done_o(n_done), .fail_cnt_o(fail_cnt), .first_fail_id_o(ff_id),
        .first_fail_status_o(ff_st), .cycles_o(cycles), .state_o(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Tile side: a pending report is offered until the tile sees its handshake.
    bit   [N-1:0]  pend = '0;
    logic [SW-1:0] pstat [N];
    bit            rand_drop = 1'b0;

    // Behavioural model of the collector's observable results.
    bit          m_run, m_done, m_to, m_dup;
    int          m_ptr, m_n_done, m_fail, m_ff_id;
    logic [SW-1:0] m_ff_st;
    longint      m_cycles;
    bit [N-1:0]  m_set;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] obs_q[$];
    int           cyc_q[$];

    task automatic model_reset();
        m_run = 0; m_done = 0; m_to = 0; m_dup = 0;
        m_ptr = 0; m_n_done = 0; m_fail = 0; m_ff_id = 0;
        m_ff_st = '0; m_cycles = 0; m_set = '0;
    endtask

    function automatic int model_grant(logic [N-1:0] v);
        if (!m_run) return -1;
        for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge(int g);
        bit expire;
        if (!rst_n) begin
            model_reset();
        end else if (!m_run && !m_done && !m_to) begin
            if (start) m_run = 1;
        end else if (m_run) begin
            expire = (m_cycles == TO - 1);
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (m_set[g]) m_dup = 1;
                else begin
                    m_set[g] = 1;
                    m_n_done++;
                    if (pstat[g] != 0) begin
                        if (m_fail == 0) begin m_ff_id = g; m_ff_st = pstat[g]; end
                        m_fail++;
                    end
                end
            end
            if (m_n_done == N) begin m_run = 0; m_done = 1; end
            else if (WD && expire) begin m_run = 0; m_to = 1; end
        end
    endtask

    // Drives one cycle per iteration and records expected/observed ready vectors.
    task automatic step(int n);
        logic [N-1:0] v, o;
        int g;
        repeat (n) begin
            for (int i = 0; i < N; i++) begin
                v[i] = pend[i] && (!rand_drop || $urandom_range(0, 3) != 0);
                eoc_if.eoc_status[i*SW +: SW] = pstat[i];
            end
            eoc_if.eoc_valid = v;
            #1;
            g = model_grant(v);
            o = eoc_if.eoc_ready;
            if (rst_n) begin
                exp_q.push_back((g >= 0) ? (N'(1) << g) : '0);
                obs_q.push_back(o);
                cyc_q.push_back(cyc);
            end
            for (int i = 0; i < N; i++) if (o[i] && v[i]) pend[i] = 1'b0;
            @(posedge clk);
            model_edge(g);
            cyc++;
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; pend = '0; rand_drop = 0;
        for (int i = 0; i < N; i++) pstat[i] = '0;
        step(2);
        rst_n = 1;
    endtask

    task automatic do_start();
        start = 1;
        step(1);
        start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pend = '1;
        step(3);
        total++; if (state !== EOC_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state, EOC_IDLE); end
        total++; if ({done, pass, timeout, dup} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {done, pass, timeout, dup}); end
        total++; if ({n_done, fail_cnt, ff_id} !== '0) begin bad++; $display("FAIL reset_counts: got %0h want 0", {n_done, fail_cnt, ff_id}); end
        total++; if ({ff_st, cycles} !== '0) begin bad++; $display("FAIL reset_status_cycles: got %0h want 0", {ff_st, cycles}); end
        total++; if (eoc_if.eoc_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0000", eoc_if.eoc_ready); end
    endtask

    task automatic test_all_pass();
        int base;
        do_reset();
        do_start();
        pend = '1;
        base = obs_q.size();
        step(4);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_q[base + k] !== (N'(1) << k)) begin bad++; $display("FAIL all_pass_order[%0d]: got %b want %b", k, obs_q[base + k], N'(1) << k); end
        end
        total++; if (done !== 1'b1 || pass !== 1'b1) begin bad++; $display("FAIL all_pass_flags: got done=%b pass=%b want 1 1", done, pass); end
        total++; if (n_done !== DW'(4)) begin bad++; $display("FAIL all_pass_n_done: got %0d want 4", n_done); end
        total++; if (cycles !== CW'(4)) begin bad++; $display("FAIL all_pass_cycles: got %0d want 4", cycles); end
    endtask

    task automatic test_fail_capture();
        do_reset();
        do_start();
        pstat[2] = 32'hDEAD;
        pend = 4'b0111;
        step(3);
        pstat[3] = 32'h1;
        pend[3] = 1'b1;
        step(2);
        total++; if (fail_cnt !== DW'(2)) begin bad++; $display("FAIL fail_cnt: got %0d want 2", fail_cnt); end
        total++; if (ff_id !== IW'(2)) begin bad++; $display("FAIL first_fail_id: got %0d want 2", ff_id); end
        total++; if (ff_st !== 32'hDEAD) begin bad++; $display("FAIL first_fail_status: got %0h want dead", ff_st); end
        total++; if (done !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL fail_flags: got done=%b pass=%b want 1 0", done, pass); end
    endtask

    task automatic test_dup();
        do_reset();
        do_start();
        pend = 4'b0011;
        step(2);
        pend[1] = 1'b1;
        step(1);
        total++; if (dup !== 1'b1) begin bad++; $display("FAIL dup_flag: got %b want 1", dup); end
        total++; if (n_done !== DW'(2)) begin bad++; $display("FAIL dup_n_done: got %0d want 2", n_done); end
        pend = 4'b1100;
        step(2);
        total++; if (done !== 1'b1 || n_done !== DW'(4) || dup !== 1'b1) begin bad++; $display("FAIL dup_finish: got done=%b n=%0d dup=%b want 1 4 1", done, n_done, dup); end
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        pend = 4'b0111;
        step(3);
        step(105);
        total++; if (n_done !== DW'(3) || done !== 1'b0) begin bad++; $display("FAIL wd_progress: got n=%0d done=%b want 3 0", n_done, done); end
        if (WD) begin
            total++; if (timeout !== 1'b1 || state !== EOC_TIMEOUT) begin bad++; $display("FAIL wd_expired: got timeout=%b state=%0d want 1 %0d", timeout, state, EOC_TIMEOUT); end
            total++; if (cycles !== CW'(TO)) begin bad++; $display("FAIL wd_cycles: got %0d want %0d", cycles, TO); end
        end else begin
            total++; if (timeout !== 1'b0 || state !== EOC_RUN) begin bad++; $display("FAIL nowd_run: got timeout=%b state=%0d want 0 %0d", timeout, state, EOC_RUN); end
            total++; if (cycles !== CW'(108)) begin bad++; $display("FAIL nowd_cycles: got %0d want 108", cycles); end
        end
        pend[3] = 1'b1;
        step(2);
        total++; if (done !== m_done || n_done !== DW'(m_n_done)) begin bad++; $display("FAIL wd_late_report: got done=%b n=%0d want %b %0d", done, n_done, m_done, m_n_done); end
    endtask

    task automatic test_timeout_race();
        do_reset();
        do_start();
        pend = 4'b0111;
        step(3);
        step(96);
        pend[3] = 1'b1;
        step(1);
        total++; if (done !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL race_state: got done=%b timeout=%b want 1 0", done, timeout); end
        total++; if (n_done !== DW'(4) || pass !== 1'b1) begin bad++; $display("FAIL race_counts: got n=%0d pass=%b want 4 1", n_done, pass); end
    endtask

    task automatic test_reset_midrun();
        int nf;
        do_reset();
        do_start();
        pstat[0] = 32'h5;
        pend = 4'b0011;
        step(3);
        rst_n = 0;
        step(1);
        rst_n = 1;
        total++; if ({done, pass, timeout, dup, n_done, fail_cnt, ff_id} !== '0) begin bad++; $display("FAIL midrst_flags: got %0h want 0", {done, pass, timeout, dup, n_done, fail_cnt, ff_id}); end
        total++; if ({ff_st, cycles} !== '0 || state !== EOC_IDLE) begin bad++; $display("FAIL midrst_state: got %0h/%0d want 0/%0d", {ff_st, cycles}, state, EOC_IDLE); end
        nf = 0;
        for (int i = 0; i < N; i++) begin
            pstat[i] = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 1000)) : '0;
            if (pstat[i] != 0) nf++;
        end
        do_start();
        pend = '1;
        step(6);
        total++; if (done !== 1'b1 || n_done !== DW'(4)) begin bad++; $display("FAIL midrst_rerun: got done=%b n=%0d want 1 4", done, n_done); end
        total++; if (fail_cnt !== DW'(nf) || pass !== (nf == 0)) begin bad++; $display("FAIL midrst_fail: got %0d pass=%b want %0d %b", fail_cnt, pass, nf, nf == 0); end
    endtask

    task automatic test_random();
        int j;
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) pstat[i] = ($urandom_range(0, 2) == 0) ? $urandom : '0;
            pend = N'($urandom_range(0, 15));
            rand_drop = 1;
            step($urandom_range(0, 3));
            do_start();
            pend = '1;
            for (int c = 0; c < 60 && !m_done && !m_to; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    j = $urandom_range(0, N - 1);
                    if (!pend[j]) begin pend[j] = 1'b1; pstat[j] = ($urandom_range(0, 1) == 1) ? $urandom : '0; end
                end
                step(1);
            end
            total++; if ({done, pass, timeout, dup} !== {m_done, m_done && m_fail == 0, m_to, m_dup}) begin bad++; $display("FAIL rnd%0d_flags: got %b want %b", r, {done, pass, timeout, dup}, {m_done, m_done && m_fail == 0, m_to, m_dup}); end
            total++; if (n_done !== DW'(m_n_done) || fail_cnt !== DW'(m_fail)) begin bad++; $display("FAIL rnd%0d_counts: got n=%0d f=%0d want %0d %0d", r, n_done, fail_cnt, m_n_done, m_fail); end
            total++; if (ff_id !== IW'(m_ff_id) || ff_st !== m_ff_st) begin bad++; $display("FAIL rnd%0d_first_fail: got %0d/%0h want %0d/%0h", r, ff_id, ff_st, m_ff_id, m_ff_st); end
            total++; if (cycles !== CW'(m_cycles)) begin bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", r, cycles, m_cycles); end
        end
        rand_drop = 0;
    endtask

    task automatic test_ready_trace();
        logic [N-1:0] e, o;
        int c;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            c = cyc_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ready_trace@%0d: got %b want %b", c, o, e); end
        end
    endtask

    initial begin
        model_reset();
        eoc_if.eoc_valid  = '0;
        eoc_if.eoc_status = '0;
        test_reset();
        test_all_pass();
        test_fail_capture();
        test_dup();
        test_timeout();
        test_timeout_race();
        test_reset_midrun();
        test_random();
        test_ready_trace();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
